// File: rtl/rd_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : rd_port_arbiter_if
//  Description : Read-side bundle between the FIFO/consumers and the
//                read-port arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface rd_port_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]    req;
    logic                  rempty;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rinc;
    logic [NUM_REQ-1:0]    gnt;
    logic [DATA_WIDTH-1:0] dout;
    logic [NUM_REQ-1:0]    dout_valid;

    // Environment side: consumers plus FIFO read port.
    modport master (
        output req, rempty, rdata,
        input  rinc, gnt, dout, dout_valid
    );

    // Arbiter side.
    modport slave (
        input  req, rempty, rdata,
        output rinc, gnt, dout, dout_valid
    );
endinterface
`default_nettype wire

// File: rtl/rd_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rd_port_arbiter
//  Description : Round-robin arbiter sharing one FIFO read port among NUM_REQ
//                consumers. Define RD_ARB_BURST_LIMIT_EN to cap pops per grant
//                at MAX_BURST.
//  Revision    : 1.0  initial release
// ============================================================================
module rd_port_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  wire logic         rclk,
    input  wire logic         rrst,
    rd_port_arbiter_if.slave  rd_if
);

    localparam int c_IDX_W = $clog2(NUM_REQ);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 16 || DATA_WIDTH < 1) begin : g_bad_param
        $error("rd_port_arbiter: parameter out of range");
    end

    state_t                r_state;
    logic [c_IDX_W-1:0]    r_owner;
    logic [c_IDX_W-1:0]    r_rr_ptr;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [NUM_REQ-1:0]    r_dout_valid;

    logic [c_IDX_W-1:0]    w_sel;
    logic [c_IDX_W-1:0]    w_next_ptr;
    logic                  w_owner_req;
    logic                  w_pop;
    logic                  w_limit_hit;
    logic                  w_release;

`ifdef RD_ARB_BURST_LIMIT_EN
    localparam int c_CNT_W = $clog2(MAX_BURST + 1);
    logic [c_CNT_W-1:0]    r_burst_cnt;
    assign w_limit_hit = w_pop & (r_burst_cnt == c_CNT_W'(MAX_BURST - 1));
`else
    assign w_limit_hit = 1'b0;
`endif

    // Lowest rotational offset from the pointer wins, so scan offsets downward.
    always_comb begin
        w_sel = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rd_if.req[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
                w_sel = c_IDX_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // gnt is one-hot on the owner, so this selects req[owner] without indexing.
    assign w_owner_req = |(rd_if.req & r_gnt);
    assign w_pop       = (r_state == ST_OWN) & w_owner_req & ~rd_if.rempty & ~rrst;
    assign w_release   = (r_state == ST_OWN) & (~w_owner_req | w_limit_hit);
    assign w_next_ptr  = (r_owner == c_IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + c_IDX_W'(1);

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_rr_ptr     <= '0;
            r_gnt        <= '0;
            r_dout       <= '0;
            r_dout_valid <= '0;
`ifdef RD_ARB_BURST_LIMIT_EN
            r_burst_cnt  <= '0;
`endif
        end else begin
            if (w_pop) begin
                r_dout       <= rd_if.rdata;
                r_dout_valid <= r_gnt;
            end else begin
                r_dout_valid <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (|rd_if.req) begin
                        r_owner <= w_sel;
                        r_gnt   <= NUM_REQ'(1) << w_sel;
                        r_state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (w_release) begin
                        r_state  <= ST_IDLE;
                        r_gnt    <= '0;
                        r_rr_ptr <= w_next_ptr;
`ifdef RD_ARB_BURST_LIMIT_EN
                        r_burst_cnt <= '0;
                    end else if (w_pop) begin
                        r_burst_cnt <= r_burst_cnt + c_CNT_W'(1);
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd_if.rinc       = w_pop;
    assign rd_if.gnt        = r_gnt;
    assign rd_if.dout       = r_dout;
    assign rd_if.dout_valid = r_dout_valid;

endmodule
`default_nettype wire

// File: doc/rd_port_arbiter.md
RD_PORT_ARBITER -- requirements
Module: rd_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of read-side consumers, range 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: FIFO word width.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum pops per grant, range 1..16.
REQ-004 SHALL have a single clock and a synchronous, active-high reset; there are no other clock or reset ports.
REQ-005 rclk  input  1  read-domain clock; all state updates on its rising edge.
REQ-006 rrst  input  1  synchronous active-high reset.
REQ-007 req  input  NUM_REQ  per-consumer read request; level, held while words are wanted.
REQ-008 rempty  input  1  FIFO read-side empty flag.
REQ-009 rdata  input  DATA_WIDTH  FIFO read data at the current read address; valid whenever rempty=0.
REQ-010 rinc  output  1  FIFO pop strobe.
REQ-011 gnt  output  NUM_REQ  registered one-hot grant; all zero when no owner.
REQ-012 dout  output  DATA_WIDTH  registered popped word.
REQ-013 dout_valid  output  NUM_REQ  registered one-hot tag naming the consumer that receives dout.

Function
REQ-014 SHALL implement FSM states IDLE and OWN.
REQ-015 IDLE: if req is nonzero, SHALL select the first set bit searching upward from rr_ptr with wrap; gnt=onehot(sel) and OWN are entered on the next edge.
REQ-016 IDLE: if req is zero, SHALL hold IDLE, gnt=0 and rinc=0.
REQ-017 OWN: rinc SHALL equal req[owner] & ~rempty, combinationally; rinc SHALL be 0 in IDLE.
REQ-018 A pop is a cycle with rinc=1; on that edge, dout<=rdata, dout_valid<=gnt and burst_cnt<=burst_cnt+1.
REQ-019 A cycle without a pop SHALL load dout_valid<=0 and hold dout.
REQ-020 Latency: a word popped in cycle t SHALL appear on dout/dout_valid in cycle t+1.
REQ-021 OWN with rempty=1 SHALL keep the grant and stall; burst_cnt holds.
REQ-022 OWN with req[owner]=0 SHALL release: next state IDLE, gnt<=0, burst_cnt<=0, rr_ptr<=(owner+1) mod NUM_REQ.
REQ-023 A pop that makes burst_cnt reach MAX_BURST SHALL release on that edge, exactly as in REQ-022.
REQ-024 Every release SHALL insert one IDLE cycle before the next grant.
REQ-025 rr_ptr SHALL wrap from NUM_REQ-1 to 0.
REQ-026 burst_cnt SHALL be wide enough to hold MAX_BURST and SHALL never exceed it.
REQ-027 Changes on req bits of non-owners SHALL have no effect while in OWN.
REQ-028 gnt SHALL never have more than one bit set, and dout_valid SHALL never have more than one bit set.
REQ-029 rinc SHALL never be 1 while rempty=1.

Reset
REQ-030 While rrst=1 at an rclk edge, the block SHALL load: state=IDLE, gnt=0, dout=0, dout_valid=0, rr_ptr=0, burst_cnt=0.
REQ-031 While rrst=1, rinc SHALL be forced to 0 combinationally.
REQ-032 Reset asserted mid-burst SHALL abandon the burst with no further pop; the first grant after reset starts the search from index 0.

Configuration
REQ-033 Macro RD_ARB_BURST_LIMIT_EN SHALL gate the burst limit.
REQ-034 With RD_ARB_BURST_LIMIT_EN defined, REQ-023 applies.
REQ-035 Without RD_ARB_BURST_LIMIT_EN, the owner SHALL keep the grant until req[owner]=0; burst_cnt and MAX_BURST are unused and REQ-023 is void.

Verification
REQ-036 Reset: rrst=1 for 2 cycles with req=4'b1111 and rempty=0 -> gnt=0, rinc=0, dout_valid=0 throughout; gnt=4'b0001 one cycle after rrst falls.
REQ-037 Round-robin: req=4'b1010 held, FIFO holding 20 words, burst limit enabled -> grants alternate 0010, 1000, 0010 with 4 pops each and one idle cycle between grants.
REQ-038 Empty stall: owner 2 granted, FIFO holding 1 word -> one pop with dout_valid=4'b0100 the following cycle; then rinc=0 while gnt stays 4'b0100 until rempty falls.
REQ-039 Early release: owner 0 drops req after 2 pops -> gnt=0 next cycle; req=4'b0001 reasserted -> re-grant to 0 only if no other request is pending, and rr_ptr=1.
REQ-040 Reset mid-burst: rrst=1 after the 2nd pop of owner 3 -> no further rinc; after release, req=4'b1001 -> gnt=4'b0001.
REQ-041 Macro off: req=4'b0100 held, FIFO holding 10 words -> 10 consecutive pops with no release, and dout matches FIFO order.
